// File: rtl/fec_rx_deframer.sv
// Serial-to-parallel front end for the 2D-parity FEC decoder: collects one framed
// bit stream into data/row/column parity registers and handshakes with the decoder.
module fec_rx_deframer #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     s_data,
   input  logic                     s_sof,
   output logic [WIDTH*DEPTH-1:0]   dec_data,
   output logic [DEPTH-1:0]         dec_row_parity,
   output logic [WIDTH-1:0]         dec_col_parity,
   output logic                     dec_ready,
   input  logic                     dec_complete,
   output logic                     frame_err,
   output logic                     timeout_err,
   output logic                     busy
);

   localparam int WD = WIDTH * DEPTH;
   localparam int N  = WD + DEPTH + WIDTH;
   localparam int CW = $clog2(N + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, COLLECT, HANDOFF, WAIT_LOW, WAIT_HIGH} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [N-1:0]    shadow, shadow_next;
   logic [TW-1:0]   tcnt;
   logic            run;
   logic            accept, sof_hit, last_hit, waiting, dec_done, t_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         run   <= 1'b1;
      end
   end

   assign accept   = s_valid && s_ready;
   assign sof_hit  = accept && s_sof && (state == IDLE || state == COLLECT);
   assign last_hit = accept && !s_sof && (state == COLLECT) && (cnt == LAST_BIT);
   assign waiting  = (state == WAIT_LOW) || (state == WAIT_HIGH);
   assign dec_done = ((state == WAIT_LOW) && !dec_complete) ||
                     ((state == WAIT_HIGH) && dec_complete);
   assign t_expire = waiting && (tcnt == T_LAST);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (sof_hit) state_next = COLLECT;
         COLLECT:   if (last_hit) state_next = HANDOFF;
         HANDOFF:   state_next = WAIT_LOW;
         WAIT_LOW:  if (!dec_complete) state_next = WAIT_HIGH;
                    else if (t_expire) state_next = IDLE;
         WAIT_HIGH: if (dec_complete || t_expire) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // run keeps s_ready low while reset is held and in the first cycle after it
   always_comb begin
      s_ready     = run && (state == IDLE || state == COLLECT);
      busy        = (state != IDLE);
      dec_ready   = (state == HANDOFF);
      timeout_err = t_expire && !dec_done;
   end

   always_comb begin
      shadow_next = shadow;
      cnt_next    = cnt;
      if (sof_hit) begin
         shadow_next    = '0;
         shadow_next[0] = s_data;
         cnt_next       = CW'(1);
      end else if (accept && state == COLLECT) begin
         shadow_next[cnt] = s_data;
         cnt_next         = last_hit ? '0 : cnt + CW'(1);
      end
   end

   // Outputs load with the final bit merged in, so they are valid while dec_ready is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow         <= '0;
         cnt            <= '0;
         tcnt           <= '0;
         frame_err      <= 1'b0;
         dec_data       <= '0;
         dec_row_parity <= '0;
         dec_col_parity <= '0;
      end else begin
         shadow    <= shadow_next;
         cnt       <= cnt_next;
         frame_err <= sof_hit && (state == COLLECT);
         if (last_hit) begin
            dec_data       <= shadow_next[WD-1:0];
            dec_row_parity <= shadow_next[WD +: DEPTH];
            dec_col_parity <= shadow_next[WD+DEPTH +: WIDTH];
         end
         if (state == HANDOFF) tcnt <= '0;
         else if (waiting)     tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_fec_rx_deframer.sv
// Bench for fec_rx_deframer: table of frames plus hand sequences for reset,
// back-to-back stall, timeout and the timeout/complete tie.
module tb_fec_rx_deframer;

   localparam int W = 4;
   localparam int D = 4;
   localparam int T = 64;
   localparam int N = W*D + D + W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          s_data = 1'b0;
   logic          s_sof = 1'b0;
   logic [W*D-1:0] dec_data;
   logic [D-1:0]  dec_row_parity;
   logic [W-1:0]  dec_col_parity;
   logic          dec_ready;
   logic          dec_complete;
   logic          frame_err;
   logic          timeout_err;
   logic          busy;

   fec_rx_deframer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .dec_data(dec_data),
      .dec_row_parity(dec_row_parity), .dec_col_parity(dec_col_parity),
      .dec_ready(dec_ready), .dec_complete(dec_complete),
      .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  row;
      logic [3:0]  col;
      bit          gap;
      int          early;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  row;
      logic [3:0]  col;
   } frame_t;

   frame_t sb[$];
   frame_t got;
   int passes = 0, total = 0;
   int ready_cnt = 0, ferr_cnt = 0, terr_cnt = 0, pushed = 0;

   // Decoder model: complete drops the cycle after next following ready,
   // and is high again at ready + rise_dm + 1
   bit stuck = 1'b0;
   int rise_dm = 5;
   int dm;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_complete <= 1'b1;
         dm <= 0;
      end else if (dm != 0) begin
         dm <= dm + 1;
         if (dm == 1) dec_complete <= 1'b0;
         if (dm == rise_dm) begin
            dec_complete <= 1'b1;
            dm <= 0;
         end
      end else if (dec_ready && !stuck) begin
         dm <= 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dec_ready) begin
            ready_cnt++;
            if (sb.size() == 0) chk("unexpected_ready", 32'(dec_ready), 32'd0);
            else begin
               got = sb.pop_front();
               chk("dec_data", 32'(dec_data), 32'(got.data));
               chk("dec_row_parity", 32'(dec_row_parity), 32'(got.row));
               chk("dec_col_parity", 32'(dec_col_parity), 32'(got.col));
            end
         end
         if (frame_err) ferr_cnt++;
         if (timeout_err) terr_cnt++;
      end
   end

   task automatic drive_bit(input logic b, input logic sof, input bit gap, output int waited);
      if (gap) begin
         s_valid = 1'b0;
         s_sof   = 1'b1;
         s_data  = 1'($urandom);
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      s_sof   = sof;
      waited  = 0;
      while (!s_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) chk("accept_wait", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] d, input logic [3:0] r, input logic [3:0] c,
                             input bit gap, input logic exp_ferr, output int first_wait);
      logic [N-1:0] bits;
      frame_t f;
      int w;
      bits = {c, r, d};
      f.data = d; f.row = r; f.col = c;
      sb.push_back(f);
      pushed++;
      first_wait = 0;
      for (int k = 0; k < N; k++) begin
         drive_bit(bits[k], k == 0, gap, w);
         if (k == 0) begin
            first_wait = w;
            chk("frame_err_at_sof", 32'(frame_err), 32'(exp_ferr));
         end
      end
   endtask

   task automatic wait_done(output int lat);
      int g;
      g = 0;
      while (!dec_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!dec_ready) chk("ready_seen", 32'(dec_ready), 32'd1);
      lat = 0;
      while (!s_ready && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t vecs[5];
   int w, lat;

   initial begin
      vecs[0] = '{16'hA5C3, 4'h5, 4'h9, 1'b0, 0};
      vecs[1] = '{16'hA5C3, 4'h5, 4'h9, 1'b1, 0};
      vecs[2] = '{16'hFFFF, 4'hF, 4'hF, 1'b0, 10};
      vecs[3] = '{16'h0001, 4'h8, 4'h1, 1'b1, 0};
      vecs[4] = '{16'h8000, 4'h1, 4'h8, 1'b0, 0};

      repeat (3) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dec_data", 32'(dec_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].early; k++) drive_bit(1'($urandom), k == 0, 1'b0, w);
         send_frame(vecs[i].data, vecs[i].row, vecs[i].col, vecs[i].gap,
                    vecs[i].early > 0, w);
         wait_done(lat);
         chk("handoff_latency", 32'(lat), 32'd7);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Reset in the middle of a frame, with s_valid toggling under reset
      for (int k = 0; k < 8; k++) drive_bit(1'($urandom), k == 0, 1'b0, w);
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s_valid = ~s_valid;
         s_data  = 1'($urandom);
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_dec_data", 32'(dec_data), 32'd0);
      chk("midrst_row", 32'(dec_row_parity), 32'd0);
      chk("midrst_col", 32'(dec_col_parity), 32'd0);
      chk("midrst_ready", 32'(dec_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_rel_ready", 32'(dec_ready), 32'd0);
      chk("midrst_rel_s_ready", 32'(s_ready), 32'd1);

      // Back-to-back: second frame stalls until the first completes
      send_frame(16'h1234, 4'h3, 4'hC, 1'b0, 1'b0, w);
      send_frame(16'hBEEF, 4'hA, 4'h6, 1'b0, 1'b0, w);
      chk("b2b_stall", 32'(w), 32'd7);
      wait_done(lat);
      chk("b2b_latency", 32'(lat), 32'd7);

      // complete rises in the very cycle the timeout would fire
      rise_dm = T - 1;
      send_frame(16'h5A5A, 4'h6, 4'h3, 1'b0, 1'b0, w);
      wait_done(lat);
      chk("tie_latency", 32'(lat), 32'(T + 1));
      @(negedge clk);
      chk("tie_no_timeout", 32'(terr_cnt), 32'd0);

      // Decoder never handshakes
      rise_dm = 5;
      stuck = 1'b1;
      send_frame(16'hC0DE, 4'h9, 4'h2, 1'b0, 1'b0, w);
      lat = 0;
      while (!timeout_err && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("timeout_cycle", 32'(lat), 32'(T));
      @(negedge clk);
      chk("timeout_pulse_width", 32'(timeout_err), 32'd0);
      chk("timeout_s_ready", 32'(s_ready), 32'd1);
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_data_hold", 32'(dec_data), 32'h0000C0DE);
      stuck = 1'b0;

      repeat (3) @(negedge clk);
      chk("frame_err_count", 32'(ferr_cnt), 32'd1);
      chk("timeout_count", 32'(terr_cnt), 32'd1);
      chk("ready_count", 32'(ready_cnt), 32'(pushed));
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, total);
      $fatal(1);
   end

endmodule

// File: doc/fec_rx_deframer.md
Name: fec_rx_deframer

Overview:
- Upstream stage of the 2D-parity FEC decoder. Accepts a bit-serial frame carrying data plus row and column parity, assembles it into the decoder's matrix and parity ports, and issues the decoder's one-cycle ready.
- Backpressures the serial link until the decoder signals completion.
- Flags framing errors and decoder timeouts so the link layer can resynchronise.

Parameters:
- WIDTH, 4, matrix width (column parity bits), matches decoder.
- DEPTH, 4, matrix depth (row parity bits), matches decoder.
- TIMEOUT, 64, max cycles to wait for the decoder handshake before aborting; must be at least 8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  serial bit valid.
- s_ready  out  1  deframer accepts a bit this cycle.
- s_data  in  1  serial bit.
- s_sof  in  1  marks the first bit of a frame; qualified by s_valid.
- dec_data  out  WIDTH*DEPTH  assembled data; drives the decoder data_in packed vector.
- dec_row_parity  out  DEPTH  to decoder row_parity.
- dec_col_parity  out  WIDTH  to decoder col_parity.
- dec_ready  out  1  one-cycle start pulse to the decoder.
- dec_complete  in  1  decoder complete.
- frame_err  out  1  one-cycle pulse: frame aborted by an early sof.
- timeout_err  out  1  one-cycle pulse: decoder handshake timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Frame length N = WIDTH*DEPTH + DEPTH + WIDTH (24 at defaults). A bit is accepted when s_valid && s_ready.
- Bit ordering, first accepted bit is bit 0:
  - Bits 0..WIDTH*DEPTH-1 go to dec_data[k], LSB first.
  - The next DEPTH bits go to dec_row_parity[0..DEPTH-1].
  - The last WIDTH bits go to dec_col_parity[0..WIDTH-1].
- Internal bit counter is $clog2(N+1) bits wide. The shadow shift buffer is separate from the output registers. Outputs update only on handoff, so they stay stable throughout decode.
- Reset values: s_ready=0, dec_data=0, dec_row_parity=0, dec_col_parity=0, dec_ready=0, frame_err=0, timeout_err=0, busy=0, state=IDLE, counter=0.
- IDLE:
  - s_ready=1.
  - An accepted bit with s_sof=1 is stored as bit 0, counter=1, go to COLLECT.
  - Accepted bits without sof are discarded.
- COLLECT:
  - s_ready=1. Each accepted bit is stored at the counter position and the counter increments.
  - Accepted bit with s_sof=1 (early sof): pulse frame_err for one cycle, discard the partial frame, store this bit as bit 0, counter=1, stay in COLLECT.
  - Accepting bit N-1 (without sof): go to HANDOFF.
  - s_valid=0 cycles stall with no timeout.
- HANDOFF (1 cycle):
  - s_ready=0.
  - Copy the shadow buffer into dec_data and the parity outputs.
  - Assert dec_ready=1 on the same cycle the outputs become valid.
  - Clear the timeout counter. Go to WAIT_LOW.
- WAIT_LOW:
  - s_ready=0, dec_ready=0.
  - Wait for dec_complete=0, which confirms the decoder left IDLE, then go to WAIT_HIGH.
- WAIT_HIGH:
  - s_ready=0.
  - Wait for dec_complete=1, which is the decoder's SET result, then go to IDLE.
  - The timeout counter keeps running across WAIT_LOW and WAIT_HIGH.
- Timeout:
  - Condition: the timeout counter reaches TIMEOUT-1 in WAIT_LOW or WAIT_HIGH.
  - Action: pulse timeout_err, go to IDLE.
  - Output registers hold their values.
- Simultaneity:
  - If dec_complete transitions and the timeout fire in the same cycle, the transition wins and timeout_err stays 0.
  - In IDLE, s_sof=1 with s_valid=0 is ignored.
- busy = (state != IDLE).
- Reset mid-operation: all state returns to reset values immediately. A partially collected frame is lost. dec_ready=0 is guaranteed in the cycle after reset deassertion.

Test Plan:
- Reset: hold rst_n=0 mid-COLLECT with s_valid toggling -> all outputs 0, state IDLE; after release s_ready=1, busy=0.
- Nominal frame:
  - Stimulus: sof plus 24 bits (data 16'hA5C3, row parity 4'b0101, col parity 4'b1001), valid every cycle. Decoder model: complete drops 2 cycles after ready and returns 4 cycles later.
  - Required: dec_data=16'hA5C3, dec_row_parity=4'h5, dec_col_parity=4'h9; dec_ready is a single pulse in the cycle after bit 23; s_ready=0 until complete rises, then 1.
- Gapped input: same frame with s_valid low every other cycle -> identical outputs; dec_ready pulses exactly once.
- Early sof: sof at bit 10 of frame A, then a full frame B -> frame_err pulses once on the cycle after bit 10; dec_data equals frame B.
- Timeout: decoder model holds complete=1 forever -> timeout_err pulses once at cycle TIMEOUT after HANDOFF; state IDLE; s_ready=1; dec_data holds.
- Back-to-back: two frames, the second offered immediately -> the second frame is stalled (s_ready=0) until the first frame's complete rises; both handoffs are correct and in order.
